// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1 -- N-to-1 channel selector with a one-entry registered output.
//
// Selects one of N WIDTH-bit input channels, either by an external index
// (fixed mode) or by round-robin arbitration among valid channels, and
// forwards the chosen beat through a single output register. Every channel
// and the output use valid/ready handshakes.
//
// Optional feature (define MUX_ARB_LOCK_EN): packet lock. Adds in_last; in
// round-robin mode the grant stays on a channel until its last beat.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   in_last    per-channel end-of-packet marker (MUX_ARB_LOCK_EN only)
//   sel        channel index used in fixed mode
//   rr_mode    0 = fixed select, 1 = round-robin
//   out_data   registered data
//   out_src    registered index of the supplying channel
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
module mux_arb_nto1 #(
  parameter int WIDTH = 3,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  input  logic [SELW-1:0]      sel,
  input  logic                 rr_mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             load_en;
  logic             xfer;
  logic             last_beat;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  grant_inc;
  int unsigned      idx;

`ifdef MUX_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [SELW-1:0]  lock_src_q, lock_src_d;
`endif

  always_comb begin
    load_en    = !out_valid_q | out_ready;
    grant      = '0;
    grant_vld  = 1'b0;
    idx        = 0;
    grant_data = '0;
    grant_inc  = '0;

    if (!rr_mode) begin
      grant     = sel;
      grant_vld = (32'(sel) < 32'(N));
    end else begin
`ifdef MUX_ARB_LOCK_EN
      if (lock_q) begin
        grant     = lock_src_q;
        grant_vld = 1'b1;
      end else begin
`endif
        // Scan ptr, ptr+1, ..., wrapping modulo N; first valid channel wins.
        for (int unsigned k = 0; k < 32'(N); k++) begin
          idx = 32'(ptr_q) + k;
          if (idx >= 32'(N)) idx = idx - 32'(N);
          if (!grant_vld && in_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = SELW'(idx);
          end
        end
`ifdef MUX_ARB_LOCK_EN
      end
`endif
    end

    // Ready is not masked by in_valid, so a waiting producer sees it.
    in_ready = '0;
    if (rst_n && grant_vld) in_ready[grant] = load_en;

    // At most one in_ready bit is set, so the reduction picks the grant.
    xfer = |(in_ready & in_valid);
`ifdef MUX_ARB_LOCK_EN
    last_beat = |(in_ready & in_valid & in_last);
`else
    last_beat = 1'b1;
`endif

    for (int unsigned i = 0; i < 32'(N); i++) begin
      if (32'(grant) == i) grant_data = in_data[i*WIDTH +: WIDTH];
    end

    if (32'(grant) == 32'(N - 1)) grant_inc = '0;
    else                          grant_inc = grant + SELW'(1);

    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;

    if (xfer) begin
      out_data_d  = grant_data;
      out_src_d   = grant;
      out_valid_d = 1'b1;
      if (rr_mode && last_beat) ptr_d = grant_inc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

`ifdef MUX_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (!rr_mode) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      lock_d     = !last_beat;
      lock_src_d = grant;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_src_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end
`endif

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1 -- directed bench for mux_arb_nto1 (N=8 default and N=5).
module tb_mux_arb_nto1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: WIDTH=3, N=8
  logic        rst_n;
  logic [23:0] in_data;
  logic [7:0]  in_valid, in_ready;
  logic [7:0]  in_last;
  logic [2:0]  sel, out_data, out_src;
  logic        rr_mode, out_valid, out_ready;

  // Non-power-of-two instance: WIDTH=3, N=5
  logic        rst5_n;
  logic [14:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic [4:0]  in_last5;
  logic [2:0]  sel5, out_data5, out_src5;
  logic        rr_mode5, out_valid5, out_ready5;

  int n_cmp = 0;
  int n_err = 0;
  int exp_src[6] = '{0, 2, 7, 0, 2, 7};

  mux_arb_nto1 #(.WIDTH(3), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last),
`endif
    .sel(sel), .rr_mode(rr_mode), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_nto1 #(.WIDTH(3), .N(5)) dut5 (
    .clk(clk), .rst_n(rst5_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last5),
`endif
    .sel(sel5), .rr_mode(rr_mode5), .out_data(out_data5), .out_src(out_src5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst5_n = 1'b0;
    in_valid = '0; in_last = '0; sel = 3'd3; rr_mode = 1'b0; out_ready = 1'b0;
    in_valid5 = '0; in_last5 = '0; sel5 = '0; rr_mode5 = 1'b0; out_ready5 = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*3 +: 3] = 3'(i);
    for (int i = 0; i < 5; i++) in_data5[i*3 +: 3] = 3'(i);
    in_valid = 8'hFF;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_src",   32'(out_src),   0);
    chk("rst_ready_forced0", 32'(in_ready), 0);

    // Fixed select of channel 3 at full throughput
    @(negedge clk);
    rst_n = 1'b1; rst5_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("fix3_in_ready", 32'(in_ready), 32'h08);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("fix3_data",  32'(out_data),  3);
      chk("fix3_src",   32'(out_src),   3);
      chk("fix3_valid", 32'(out_valid), 1);
    end

    // Fixed select of channel 5, then a 3-cycle stall
    sel = 3'd5;
    cyc();
    chk("fix5_data", 32'(out_data), 5);
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", 32'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("stall_data",     32'(out_data),  5);
      chk("stall_src",      32'(out_src),   5);
      chk("stall_valid",    32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready),  0);
    end
    // Release; ready on sel is asserted even with no valid input
    out_ready = 1'b1; in_valid = 8'h00;
    #1;
    chk("unmasked_ready", 32'(in_ready), 32'h20);
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_hold",  32'(out_data),  5);

    // Round-robin over channels 0, 2, 7 with wrap
    rr_mode = 1'b1; in_valid = 8'h85;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h01);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("rr_src",  32'(out_src),  32'(exp_src[c]));
      chk("rr_data", 32'(out_data), 32'(exp_src[c]));
    end

    // Only channel 6, then channel 1 added: scan starts at 7 and wraps
    in_valid = 8'h40;
    #1;
    chk("rr6_ready", 32'(in_ready), 32'h40);
    cyc();
    chk("rr6_src", 32'(out_src), 6);
    in_valid = 8'h42;
    #1;
    chk("rr_wrap_ready", 32'(in_ready), 32'h02);
    cyc();
    chk("rr_wrap_src", 32'(out_src), 1);

    // Mode change takes effect at once; ptr (now 2) is retained
    rr_mode = 1'b0; sel = 3'd6;
    #1;
    chk("modechg_ready", 32'(in_ready), 32'h40);
    cyc();
    chk("modechg_src", 32'(out_src), 6);
    rr_mode = 1'b1;
    #1;
    chk("ptr_kept_ready", 32'(in_ready), 32'h40);
    cyc();
    chk("ptr_kept_src", 32'(out_src), 6);

    // Mid-stream reset (ptr was 7): beat dropped immediately, ptr back to 0
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_src",   32'(out_src),   0);
    chk("midrst_ready", 32'(in_ready),  0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 8'hC0;
    #1;
    chk("ptr_reset_ready", 32'(in_ready), 32'h40);
    cyc();
    chk("ptr_reset_src",   32'(out_src),   6);
    chk("ptr_reset_valid", 32'(out_valid), 1);

`ifdef MUX_ARB_LOCK_EN
    // ptr=7: channel 1 sends 3 beats (last on the third), then channel 4
    in_valid = 8'h12; in_last = 8'h00;
    cyc();
    chk("lock_b1", 32'(out_src), 1);
    chk("lock_held_ready", 32'(in_ready), 32'h02);
    cyc();
    chk("lock_b2", 32'(out_src), 1);
    in_last = 8'h02;
    cyc();
    chk("lock_b3", 32'(out_src), 1);
    chk("lock_release_ready", 32'(in_ready), 32'h10);
    cyc();
    chk("lock_next", 32'(out_src), 4);
    in_last = 8'h00;
`endif

    // N=5 instance: out-of-range select grants nothing
    rr_mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    #1;
    chk("n5_oor_ready", 32'(in_ready5), 0);
    cyc();
    chk("n5_oor_valid", 32'(out_valid5), 0);
    sel5 = 3'd4;
    #1;
    chk("n5_sel4_ready", 32'(in_ready5), 32'h10);
    cyc();
    chk("n5_sel4_valid", 32'(out_valid5), 1);
    chk("n5_sel4_data",  32'(out_data5),  4);
    // Asynchronous reset away from any clock edge
    #2;
    rst5_n = 1'b0;
    #1;
    chk("n5_async_valid", 32'(out_valid5), 0);
    chk("n5_async_data",  32'(out_data5),  0);
    @(negedge clk);
    rst5_n = 1'b1; rr_mode5 = 1'b1; in_valid5 = 5'h11;
    #1;
    chk("n5_rr_ready", 32'(in_ready5), 32'h01);
    cyc();
    chk("n5_rr_src0", 32'(out_src5), 0);
    cyc();
    chk("n5_rr_src4", 32'(out_src5), 4);
    cyc();
    chk("n5_rr_wrap", 32'(out_src5), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised successor to the combinational 8-to-1 selector.
- Selects one of N W-bit input channels and forwards it through a one-entry registered output stage with valid/ready handshakes on every channel.
- Two selection modes: fixed select, where an external `sel` chooses the channel, and round-robin arbitration among valid channels.
- Sits between several producer blocks and a single consumer in datapath designs.

Parameters:
- WIDTH, 3, data bits per channel
- N, 8, number of input channels (2..16, need not be a power of two)
- SELW, $clog2(N), select/source index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- sel  input  SELW  channel index used in fixed mode
- rr_mode  input  1  0 = fixed select, 1 = round-robin
- out_data  output  WIDTH  registered data
- out_src  output  SELW  registered index of the channel that supplied out_data
- out_valid  output  1  output holds a beat
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. in_ready is forced to 0 while in reset.
- load_en = !out_valid | out_ready. This is a combinational path from out_ready to in_ready; accept it.
- Grant g, when rr_mode=0:
  - g = sel.
  - If sel >= N: no grant, in_ready = 0, nothing is transferred.
- Grant g, when rr_mode=1:
  - g = the first i with in_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - No valid channel: no grant.
- in_ready[g] = load_en. All other in_ready bits are 0. At most one bit is ever set.
- Input transfer happens when in_valid[g] & in_ready[g]. On the next edge: out_data <= channel g data, out_src <= g, out_valid <= 1.
- Latency is 1 cycle, input transfer to out_valid.
- Full throughput is 1 beat/cycle while out_ready=1.
- Output transfer happens when out_valid & out_ready. If there is no simultaneous input transfer, out_valid <= 0 and out_data/out_src hold their last value. If there is one, the new beat is loaded in the same cycle.
- Stall: while out_valid=1 and out_ready=0, out_data and out_src are stable, and all in_ready bits are 0.
- Pointer update:
  - On each input transfer in round-robin mode, ptr <= g+1, wrapping from N-1 to 0.
  - In fixed mode ptr holds its value.
- Mode change (rr_mode toggle) takes effect in the same cycle's grant computation. ptr is retained across the change.
- The selection path must not be masked by in_valid. In fixed mode, in_ready[sel] is asserted even when in_valid[sel]=0.
- Reset asserted mid-stream: the pending output beat is discarded and ptr returns to 0.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN (packet lock).
- With the macro defined:
  - Extra input port in_last, N bits, marking the final beat of a packet per channel.
  - In round-robin mode, after a transfer from channel g with in_last[g]=0, the grant is locked to g. Other valid channels are ignored until a transfer from g with in_last[g]=1.
  - While locked, ptr is not advanced; it advances to g+1 on the last beat.
  - The lock flag resets to 0.
  - In fixed mode the lock is ignored and cleared.
- Without the macro: the in_last port is absent, and every beat is arbitrated independently.

Test Plan:
- Defaults, reset then rr_mode=0, sel=3, in_valid=8'hFF, channel i data=i, out_ready=1 → in_ready=8'b0000_1000; from the next cycle out_data=3, out_src=3, out_valid=1 every cycle.
- Fixed mode, sel=5, out_ready=0 for 3 cycles after the first beat → out_data=5 held stable, in_ready=0 during the stall; the beat is released when out_ready returns to 1.
- rr_mode=1, in_valid=8'b1000_0101, out_ready=1 → out_src sequence 0,2,7,0,2,7; ptr wraps from 7 to 0.
- rr_mode=1, only channel 6 valid, then channel 1 added → 6 is granted; next grant is 1 (scan starts at 7 and wraps).
- N=5 build, rr_mode=0, sel=6 → in_ready=0, out_valid stays 0; rst_n pulsed low while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge.
- MUX_ARB_LOCK_EN, rr_mode=1, channels 1 and 4 valid, channel 1 sending 3 beats with in_last on the third → out_src=1,1,1,4.
